// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, bit indices, reset values.
// The IRQ_MASK offset is decoded only when MMIO_IRQ_EN is defined.
package mmio_pkg;

  localparam logic [5:0] OFS_PORT_IN  = 6'h00;
  localparam logic [5:0] OFS_PORT_OUT = 6'h04;
  localparam logic [5:0] OFS_STATUS   = 6'h08;
  localparam logic [5:0] OFS_TMR_CMP  = 6'h0C;
  localparam logic [5:0] OFS_TMR_CNT  = 6'h10;
  localparam logic [5:0] OFS_CTRL     = 6'h14;
  localparam logic [5:0] OFS_IRQ_MASK = 6'h18;

  localparam int STATUS_IN_CHG    = 0;
  localparam int STATUS_TMR_EXP   = 1;
  localparam int CTRL_TMR_EN      = 0;
  localparam int CTRL_AUTO_RELOAD = 1;

  localparam logic [31:0] PORT_OUT_RST = 32'h0000_0000;
  localparam logic [31:0] TMR_CNT_RST  = 32'h0000_0000;
  localparam logic [31:0] TMR_CMP_RST  = 32'hFFFF_FFFF;
  localparam logic [1:0]  IRQ_MASK_RST = 2'b00;

  typedef struct packed {
    logic auto_reload;
    logic tmr_en;
  } ctrl_t;

  function automatic logic ofs_mapped(input logic [5:0] ofs);
    logic mapped;
    case (ofs)
      OFS_PORT_IN, OFS_PORT_OUT, OFS_STATUS,
      OFS_TMR_CMP, OFS_TMR_CNT, OFS_CTRL: mapped = 1'b1;
`ifdef MMIO_IRQ_EN
      OFS_IRQ_MASK: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
    return mapped;
  endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the MMIO responder (slave).
interface mmio_port_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Hit
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_timer.sv
// Compare timer: free-running counter with compare match, optional auto-reload and enable FSM.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output ctrl_t       ctrl,
  output logic        exp_pulse
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d, state_nxt;
  logic [31:0] cnt_q, cnt_d, cnt_nxt;
  logic [31:0] cmp_q, cmp_d;
  logic        auto_q, auto_d;

  // Timer's own next state; CPU writes then override it below.
  always_comb begin
    cnt_nxt   = cnt_q;
    state_nxt = state_q;
    exp_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_nxt   = cnt_q;
        state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q == cmp_q) begin
          exp_pulse = 1'b1;
          cnt_nxt   = auto_q ? TMR_CNT_RST : cnt_q;
          state_nxt = auto_q ? ST_RUN : ST_IDLE;
        end else begin
          cnt_nxt   = cnt_q + 32'd1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        cnt_nxt   = cnt_q;
        state_nxt = ST_IDLE;
      end
    endcase
    cnt_d   = cnt_we ? wdata : cnt_nxt;
    cmp_d   = cmp_we ? wdata : cmp_q;
    state_d = ctrl_we ? (wdata[CTRL_TMR_EN] ? ST_RUN : ST_IDLE) : state_nxt;
    auto_d  = ctrl_we ? wdata[CTRL_AUTO_RELOAD] : auto_q;
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= TMR_CNT_RST;
      cmp_q   <= TMR_CMP_RST;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      auto_q  <= auto_d;
    end
  end

  always_comb begin
    cnt              = cnt_q;
    cmp              = cmp_q;
    ctrl.tmr_en      = (state_q == ST_RUN);
    ctrl.auto_reload = auto_q;
  end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: register window decode, synchronized input port, output port, compare timer.
// Define MMIO_IRQ_EN to add the IRQ_MASK register and the registered Irq output.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          PORTIN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_port_responder_if.slave    bus,
  input  logic [PORTIN_WIDTH-1:0] PortIn,
  output logic [31:0]             PortOut
`ifdef MMIO_IRQ_EN
  ,
  output logic                    Irq
`endif
);

  logic [5:0]              ofs;
  logic                    hit, rd_hit, wr_hit, rd_status;
  logic                    port_out_we, cmp_we, cnt_we, ctrl_we;
  logic [PORTIN_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [31:0]             port_out_q, port_out_d;
  logic                    in_chg_q, in_chg_d, tmr_exp_q, tmr_exp_d;
  logic [31:0]             tmr_cnt, tmr_cmp, status, rdata;
  ctrl_t                   tmr_ctrl;
  logic                    tmr_exp;
`ifdef MMIO_IRQ_EN
  logic [1:0]              irq_mask_q, irq_mask_d;
  logic                    irq_q, irq_d, irq_mask_we;
`endif

  // Window decode and per-register strobes; Hit ignores MemRead/MemWrite.
  always_comb begin
    ofs         = bus.Address[5:0];
    hit         = (bus.Address[31:6] == BASE_ADDR[31:6]) &&
                  (bus.Address[1:0] == 2'b00) && ofs_mapped(ofs);
    rd_hit      = bus.MemRead && hit;
    wr_hit      = bus.MemWrite && hit;
    rd_status   = rd_hit && (ofs == OFS_STATUS);
    port_out_we = wr_hit && (ofs == OFS_PORT_OUT);
    cmp_we      = wr_hit && (ofs == OFS_TMR_CMP);
    cnt_we      = wr_hit && (ofs == OFS_TMR_CNT);
    ctrl_we     = wr_hit && (ofs == OFS_CTRL);
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .cnt_we    (cnt_we),
    .cmp_we    (cmp_we),
    .ctrl_we   (ctrl_we),
    .wdata     (bus.WriteData),
    .cnt       (tmr_cnt),
    .cmp       (tmr_cmp),
    .ctrl      (tmr_ctrl),
    .exp_pulse (tmr_exp)
  );

  // Synchronizer chain, output port and sticky flags (a set beats a read-clear).
  always_comb begin
    s1_d       = PortIn;
    s2_d       = s1_q;
    s3_d       = s2_q;
    port_out_d = port_out_we ? bus.WriteData : port_out_q;
    in_chg_d   = (s2_q != s3_q) ? 1'b1 : (rd_status ? 1'b0 : in_chg_q);
    tmr_exp_d  = tmr_exp ? 1'b1 : (rd_status ? 1'b0 : tmr_exp_q);
  end

  // Port and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      port_out_q <= PORT_OUT_RST;
      in_chg_q   <= 1'b0;
      tmr_exp_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      port_out_q <= port_out_d;
      in_chg_q   <= in_chg_d;
      tmr_exp_q  <= tmr_exp_d;
    end
  end

`ifdef MMIO_IRQ_EN
  // Irq follows the flags one edge late, so it sets and clears a cycle after STATUS does.
  always_comb begin
    irq_mask_we = wr_hit && (ofs == OFS_IRQ_MASK);
    irq_mask_d  = irq_mask_we ? bus.WriteData[1:0] : irq_mask_q;
    irq_d       = |(status[1:0] & irq_mask_q);
  end

  // Interrupt mask and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= IRQ_MASK_RST;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign Irq = irq_q;
`endif

  // Read mux: current register contents, so a same-cycle write is not visible yet.
  always_comb begin
    status                 = 32'h0000_0000;
    status[STATUS_IN_CHG]  = in_chg_q;
    status[STATUS_TMR_EXP] = tmr_exp_q;
    rdata                  = 32'h0000_0000;
    if (rd_hit) begin
      case (ofs)
        OFS_PORT_IN:  rdata = 32'(s2_q);
        OFS_PORT_OUT: rdata = port_out_q;
        OFS_STATUS:   rdata = status;
        OFS_TMR_CMP:  rdata = tmr_cmp;
        OFS_TMR_CNT:  rdata = tmr_cnt;
        OFS_CTRL:     rdata = {30'h0, tmr_ctrl};
`ifdef MMIO_IRQ_EN
        OFS_IRQ_MASK: rdata = {30'h0, irq_mask_q};
`endif
        default:      rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Hit      = hit;
  assign PortOut      = port_out_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: expectations queued with stimulus, compared on sampling.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE       = 32'hFFFF_0000;
  localparam logic [31:0] A_PORT_IN  = 32'hFFFF_0000;
  localparam logic [31:0] A_PORT_OUT = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS   = 32'hFFFF_0008;
  localparam logic [31:0] A_TMR_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_TMR_CNT  = 32'hFFFF_0010;
  localparam logic [31:0] A_CTRL     = 32'hFFFF_0014;
  localparam logic [31:0] A_IRQ_MASK = 32'hFFFF_0018;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  port_in = 8'h00;
  logic [31:0] port_out;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif
  int          passed = 0;
  int          total = 0;
  exp_t        exp_q[$];
  logic [31:0] obs_q[$];

  mmio_port_responder_if bus ();

  mmio_port_responder #(.BASE_ADDR(BASE), .PORTIN_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (port_in),
    .PortOut (port_out)
`ifdef MMIO_IRQ_EN
    ,
    .Irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    reset         = rst;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = addr;
    bus.WriteData = wdata;
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    drive(1'b0, 1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic void expect_v(input string n, input logic [31:0] v);
    exp_q.push_back('{name: n, val: v});
  endfunction

  function automatic void observe(input logic [31:0] v);
    obs_q.push_back(v);
  endfunction

  task automatic test_reset();
    exp_t e; logic [31:0] o;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, A_PORT_OUT, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_v("reset_portout", 32'h0);      observe(port_out);
    expect_v("reset_port_out", 32'h0);     rd(A_PORT_OUT); observe(bus.ReadData);
    expect_v("reset_hit", 32'h1);          observe({31'b0, bus.Hit});
    expect_v("reset_status", 32'h0);       rd(A_STATUS);   observe(bus.ReadData);
    expect_v("reset_ctrl", 32'h0);         rd(A_CTRL);     observe(bus.ReadData);
    expect_v("reset_cmp", 32'hFFFF_FFFF);  rd(A_TMR_CMP);  observe(bus.ReadData);
    expect_v("reset_cnt", 32'h0);          rd(A_TMR_CNT);  observe(bus.ReadData);
    expect_v("reset_port_in", 32'h0);      rd(A_PORT_IN);  observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_port_out();
    exp_t e; logic [31:0] o;
    expect_v("po_hit", 32'h1);             wr(A_PORT_OUT, 32'hDEAD_BEEF); observe({31'b0, bus.Hit});
    expect_v("po_value", 32'hDEAD_BEEF);   idle(); observe(port_out);
    expect_v("po_misaligned_hit", 32'h0);  wr(BASE + 32'h6, 32'h1111_1111); observe({31'b0, bus.Hit});
    expect_v("po_after_misaligned", 32'hDEAD_BEEF); idle(); observe(port_out);
    expect_v("po_other_seg_hit", 32'h0);   wr(32'h1001_0004, 32'h2222_2222); observe({31'b0, bus.Hit});
    expect_v("po_after_other_seg", 32'hDEAD_BEEF); idle(); observe(port_out);
    wr(A_PORT_IN, 32'h0000_00FF);
    wr(A_STATUS, 32'h0000_0003);
    expect_v("ro_port_in", 32'h0);         rd(A_PORT_IN);  observe(bus.ReadData);
    expect_v("ro_status", 32'h0);          rd(A_STATUS);   observe(bus.ReadData);
    expect_v("miss_rdata", 32'h0);         rd(BASE + 32'h6); observe(bus.ReadData);
    expect_v("unmapped_1c_hit", 32'h0);    rd(BASE + 32'h1C); observe({31'b0, bus.Hit});
`ifdef MMIO_IRQ_EN
    expect_v("irq_mask_hit", 32'h1);
`else
    expect_v("irq_mask_hit", 32'h0);
`endif
    rd(A_IRQ_MASK); observe({31'b0, bus.Hit});
    expect_v("hit_no_strobe", 32'h1);      drive(1'b0, 1'b0, 1'b0, A_CTRL, 32'h0); observe({31'b0, bus.Hit});
    expect_v("rdata_no_read", 32'h0);      observe(bus.ReadData);
    expect_v("rw_old_value", 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 1'b1, A_PORT_OUT, 32'h1234_5678); observe(bus.ReadData);
    expect_v("rw_new_value", 32'h1234_5678); idle(); observe(port_out);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_port_in();
    exp_t e; logic [31:0] o;
    port_in = 8'h5A;
    expect_v("pin_after1", 32'h0);         rd(A_PORT_IN); observe(bus.ReadData);
    expect_v("pin_after2", 32'h5A);        rd(A_PORT_IN); observe(bus.ReadData);
    expect_v("inchg_after3", 32'h1);       rd(A_STATUS);  observe(bus.ReadData);
    expect_v("inchg_cleared", 32'h0);      rd(A_STATUS);  observe(bus.ReadData);
    port_in = 8'h00;
    idle();
    expect_v("pin_fall_after2", 32'h0);    rd(A_PORT_IN); observe(bus.ReadData);
    expect_v("inchg_fall", 32'h1);         rd(A_STATUS);  observe(bus.ReadData);
    expect_v("inchg_fall_cleared", 32'h0); rd(A_STATUS);  observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_timer();
    exp_t e; logic [31:0] o;
    wr(A_TMR_CMP, 32'd4);
    wr(A_TMR_CNT, 32'd0);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 6; i++) begin
      expect_v($sformatf("reload_cnt%0d", i), 32'(i % 5));
      rd(A_TMR_CNT); observe(bus.ReadData);
    end
    expect_v("reload_exp", 32'h2);         rd(A_STATUS); observe(bus.ReadData);
    for (int j = 0; j < 4; j++) begin
      expect_v($sformatf("reload_period%0d", j), (j == 3) ? 32'h2 : 32'h0);
      rd(A_STATUS); observe(bus.ReadData);
    end
    wr(A_CTRL, 32'h0);
    wr(A_TMR_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      expect_v($sformatf("oneshot_cnt%0d", i), (i > 4) ? 32'd4 : 32'(i));
      rd(A_TMR_CNT); observe(bus.ReadData);
    end
    expect_v("oneshot_ctrl", 32'h0);       rd(A_CTRL);   observe(bus.ReadData);
    expect_v("oneshot_exp", 32'h2);        rd(A_STATUS); observe(bus.ReadData);
    expect_v("oneshot_clr", 32'h0);        rd(A_STATUS); observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_precedence();
    exp_t e; logic [31:0] o;
    wr(A_TMR_CMP, 32'd5);
    wr(A_TMR_CNT, 32'd10);
    wr(A_CTRL, 32'h1);
    idle();
    wr(A_TMR_CNT, 32'hFFFF_FFFF);
    expect_v("cpu_cnt_wins", 32'hFFFF_FFFF); rd(A_TMR_CNT); observe(bus.ReadData);
    expect_v("cnt_wrap", 32'h0);             rd(A_TMR_CNT); observe(bus.ReadData);
    expect_v("cnt_after_wrap", 32'h1);       rd(A_TMR_CNT); observe(bus.ReadData);
    wr(A_CTRL, 32'h0);
    expect_v("no_exp_on_wrap", 32'h0);       rd(A_STATUS);  observe(bus.ReadData);
    wr(A_TMR_CNT, 32'd0);
    wr(A_TMR_CMP, 32'd2);
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    wr(A_CTRL, 32'h3);
    expect_v("cpu_ctrl_wins", 32'h3);        rd(A_CTRL);    observe(bus.ReadData);
    wr(A_CTRL, 32'h0);
    expect_v("prec_exp", 32'h2);             rd(A_STATUS);  observe(bus.ReadData);
    expect_v("prec_clr", 32'h0);             rd(A_STATUS);  observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_status_collision();
    exp_t e; logic [31:0] o;
    wr(A_TMR_CMP, 32'd2);
    wr(A_TMR_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    expect_v("coll_old_value", 32'h0);  rd(A_STATUS); observe(bus.ReadData);
    expect_v("coll_set_wins", 32'h2);   rd(A_STATUS); observe(bus.ReadData);
    expect_v("coll_cleared", 32'h0);    rd(A_STATUS); observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e; logic [31:0] o;
    wr(A_TMR_CMP, 32'd100);
    wr(A_TMR_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    expect_v("mid_cnt2", 32'd2);          rd(A_TMR_CNT); observe(bus.ReadData);
    drive(1'b1, 1'b0, 1'b1, A_PORT_OUT, 32'hCAFE_F00D);
    expect_v("mid_cnt_cleared", 32'h0);   rd(A_TMR_CNT); observe(bus.ReadData);
    expect_v("mid_portout", 32'h0);       observe(port_out);
    expect_v("mid_ctrl", 32'h0);          rd(A_CTRL);    observe(bus.ReadData);
    expect_v("mid_cmp", 32'hFFFF_FFFF);   rd(A_TMR_CMP); observe(bus.ReadData);
    expect_v("mid_cnt_idle", 32'h0);      rd(A_TMR_CNT); observe(bus.ReadData);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask

`ifdef MMIO_IRQ_EN
  task automatic test_irq();
    exp_t e; logic [31:0] o;
    wr(A_IRQ_MASK, 32'h2);
    expect_v("irq_mask_rd", 32'h2);    rd(A_IRQ_MASK); observe(bus.ReadData);
    wr(A_TMR_CMP, 32'd1);
    wr(A_TMR_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    expect_v("irq_idle", 32'h0);       idle(); observe({31'b0, irq});
    idle();
    expect_v("irq_flag_edge", 32'h0);  idle(); observe({31'b0, irq});
    expect_v("irq_set", 32'h1);        rd(A_STATUS); observe({31'b0, irq});
    expect_v("irq_status", 32'h2);     observe(bus.ReadData);
    expect_v("irq_hold", 32'h1);       idle(); observe({31'b0, irq});
    expect_v("irq_clear", 32'h0);      idle(); observe({31'b0, irq});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e.val) $display("FAIL %s: observed %h, required %h", e.name, o, e.val);
      else passed++;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    test_reset();
    test_port_out();
    test_port_in();
    test_timer();
    test_precedence();
    test_status_collision();
    test_reset_midcount();
`ifdef MMIO_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
Memory-mapped I/O responder on the processor's MEM-stage data bus, answering the load/store requests the pipeline issues to its data segment.
- Decodes a small register window.
- Synchronizes and edge-flags the 8-bit input port.
- Holds the 32-bit output port register.
- Provides a compare timer with sticky expiry status.
- The top level muxes ReadData against the data RAM using Hit.

Parameters:
BASE_ADDR, 32'hFFFF_0000, byte base address of the register window (must be 64-byte aligned).
PORTIN_WIDTH, 8, width of the input port.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MemRead  input  1  load strobe from EX/MEM register
MemWrite  input  1  store strobe from EX/MEM register
Address  input  32  full byte address (ALU result, unoffset)
WriteData  input  32  store data
PortIn  input  PORTIN_WIDTH  asynchronous external input
ReadData  output  32  load data; combinational, same cycle as MemRead
Hit  output  1  combinational; Address decodes to a valid register
PortOut  output  32  registered output port

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Decode:
  - Hit = (Address[31:6]==BASE_ADDR[31:6]) && Address[1:0]==0 && offset is mapped.
  - Misaligned or unmapped offsets give Hit=0, no side effects.
  - Hit does not depend on MemRead/MemWrite.
- Register map (offset, access):
  - 0x00 PORT_IN (RO): synchronized PortIn, zero-extended.
  - 0x04 PORT_OUT (RW): value driven on PortOut.
  - 0x08 STATUS (RO, read-to-clear): bit0 IN_CHG, bit1 TMR_EXP; other bits 0.
  - 0x0C TMR_CMP (RW).
  - 0x10 TMR_CNT (RW; a write loads the counter).
  - 0x14 CTRL (RW): bit0 TMR_EN, bit1 AUTO_RELOAD; other bits read 0.
- ReadData: selected register when MemRead && Hit, else 32'h0. No wait states.
- Writes take effect on the clk edge where MemWrite && Hit. Writes to RO registers are ignored.
- Input sync and change detection:
  - Two-flop synchronizer (s1, s2), then history flop s3.
  - PORT_IN reads s2.
  - IN_CHG sets when s2!=s3.
  - A PortIn change shows on PORT_IN 2 edges later and sets IN_CHG on the 3rd edge.
- Timer states: IDLE (TMR_EN=0) and RUN (TMR_EN=1).
  - In RUN, TMR_CNT increments by 1 per cycle, wrapping 32'hFFFF_FFFF -> 0.
  - When TMR_CNT==TMR_CMP in RUN: set TMR_EXP.
    - AUTO_RELOAD=1: next TMR_CNT=0, stay in RUN.
    - AUTO_RELOAD=0: TMR_CNT holds, TMR_EN clears (go to IDLE).
  - TMR_CMP=0 with AUTO_RELOAD: expires every cycle from count 0.
- Read-to-clear: a STATUS read (MemRead && Hit at 0x08) clears the flags on that edge.
  - If a set event occurs on the same edge, set wins and the flag remains 1.
- Precedence:
  - A CPU write to TMR_CNT or CTRL beats the timer's own update on the same edge.
  - A simultaneous MemRead and MemWrite is legal: the read returns the pre-write value.
- Reset values: PortOut=0, TMR_CNT=0, TMR_CMP=32'hFFFF_FFFF, CTRL=0, STATUS=0, s1/s2/s3=0.
  - ReadData and Hit are combinational and follow their inputs.
  - Reset mid-count returns the timer to IDLE with all state cleared.
  - Reset overrides any same-cycle write.

Optional Feature:
MMIO_IRQ_EN
- Defined:
  - Adds output port Irq (1 bit, registered).
  - Adds register IRQ_MASK at 0x18 (RW, bits[1:0], reset 0).
  - Irq = |(STATUS[1:0] & IRQ_MASK), registered one cycle after the flag sets; reset 0.
- Undefined: no Irq port, offset 0x18 is unmapped (Hit=0).

Decomposition:
Shared package mmio_pkg:
- Offset localparams (OFS_PORT_IN..OFS_IRQ_MASK).
- STATUS/CTRL bit-index constants.
- Reset constants, e.g. TMR_CMP_RST.

One sub-module, mmio_timer: counter, compare, reload and enable FSM. Inputs are the load/write strobes; output is the expiry pulse.

Test Plan:
1. Reset, then read 0x04, 0x08, 0x14 -> all 0. Read 0x0C -> 32'hFFFF_FFFF. PortOut=0.
2. Store 32'hDEAD_BEEF to 0xFFFF_0004 -> PortOut=32'hDEAD_BEEF next edge. Store to 0xFFFF_0006 -> Hit=0, PortOut unchanged. Store to 0x1001_0004 -> Hit=0.
3. PortIn 8'h00->8'h5A -> read 0x00 gives 32'h5A after 2 edges, STATUS=1 after 3. Next STATUS read returns 1, following read returns 0.
4. TMR_CMP=4, CTRL=2'b11 -> TMR_EXP sets every 5 cycles. Count sequence 0,1,2,3,4,0. Repeat with CTRL=2'b01 -> count stops at 4, CTRL reads 0.
5. STATUS read on the exact cycle TMR_EXP sets -> ReadData shows the old value, flag remains 1 afterwards.
6. Reset asserted mid-count at TMR_CNT=3 with a simultaneous store to PORT_OUT -> after edge, TMR_CNT=0, CTRL=0, PortOut=0. With MMIO_IRQ_EN: IRQ_MASK=2, expiry -> Irq=1 one cycle later, cleared after STATUS read.
